dds_gen: RTL and testbench
==========================

// Module: dds_gen
// PURPOSE
//  Parametrised multi-waveform DDS; successor to the fixed 12-bit accumulator + full-wave ROM pair.
//  Provides a wide phase accumulator, per-sample phase offset, and selectable sine/triangle/saw/square output.
//  Sine uses a quarter-wave ROM. Adds sample-valid and wrap-sync outputs.
//  Drives DAC/test-pattern paths downstream of the frequency-control register block.
// PARAMETERS
//  PHASE_W  24  accumulator, freq_ctrl and phase_offset width; must be >= OUT_W+1 and >= LUT_AW+2
//  LUT_AW   10  quarter-wave ROM address width (2^LUT_AW entries)
//  OUT_W    12  waveform width, unsigned offset-binary
// PORTS
//  clk           in   1        single system clock
//  rst           in   1        synchronous, active-high reset
//  en            in   1        advance accumulator one step this cycle (sample request)
//  phase_clr     in   1        force accumulator to 0 this cycle
//  freq_ctrl     in   PHASE_W  phase increment per enabled cycle
//  phase_offset  in   PHASE_W  added to accumulator before lookup
//  mode          in   2        0 sine, 1 triangle, 2 sawtooth, 3 square
//  waveform      out  OUT_W    output sample
//  out_valid     out  1        waveform holds a new sample this cycle
//  sync_out      out  1        marks the sample whose accumulator step wrapped past 2^PHASE_W
// BEHAVIOUR
//  Reset: acc=0; all pipeline valids=0; waveform=2^(OUT_W-1) (midscale); out_valid=0; sync_out=0.
//  S1 edge (en=1): acc<=acc+freq_ctrl (mod 2^PHASE_W); wrap=carry-out; phase_offset and mode captured with it.
//  en=0: acc holds, inputs are not captured, no sample enters the pipe. In-flight samples still drain.
//  phase_clr=1: acc<=0 regardless of en; wrap=0; with en=1 the sample uses phase 0+offset.
//  S2: p=acc+offset (mod). q=p[MSB:MSB-1]. a=p[MSB-2 -: LUT_AW]. If q[0]=1, a=~a.
//  S3: synchronous ROM read.
//  S4 (registered waveform): latency is 3 clk from the S1 edge to waveform/out_valid.
//  Sine: r=ROM; q[1]=0 -> mid+r, q[1]=1 -> mid-r; mid=2^(OUT_W-1).
//   ROM[i]=round((2^(OUT_W-1)-1)*sin((i+0.5)*pi/2^(LUT_AW+1))), so the range is [1, 2^OUT_W-1].
//  Triangle: t=p[MSB-1 -: OUT_W]; output = p[MSB] ? ~t : t.
//  Sawtooth: p[MSB -: OUT_W].
//  Square: p[MSB] ? 0 : 2^OUT_W-1.
//  mode/offset changes take effect on the next enabled sample only; no glitch to samples in flight.
//  out_valid=1 for exactly one cycle per enabled S1 edge. Between samples the waveform holds its last value.
//  sync_out travels with its sample and is asserted only together with out_valid.
//  freq_ctrl=0: constant phase; valid samples continue; sync never fires.
//  freq_ctrl=2^(PHASE_W-1): alternate half-cycles, i.e. Nyquist.
//  Simultaneous en and phase_clr: clear wins; the sample is still produced.
//  Reset mid-operation flushes all valids. No stale sample emerges after rst deasserts.
// STRUCTURE
//  dds_pkg: MODE_SINE/MODE_TRI/MODE_SAW/MODE_SQR localparams; PIPE_LAT=3.
//  Sub-module dds_quarter_rom #(LUT_AW,OUT_W): registered-output ROM, contents computed by an elaboration-time function.
//  The top holds the accumulator, fold/unfold logic, the mode mux and the valid/sync shift registers.
// TESTING  (PHASE_W=12, LUT_AW=4, OUT_W=8 unless noted)
//  Reset: rst high 3 cycles -> waveform=128, out_valid=0, sync_out=0. Stays so with en=0.
//  Square, freq=1024, en=1 continuous -> first valid 3 clk after first en edge.
//   Sequence 255,0,0,255 repeating. sync_out on each 4th sample (acc=0).
//  Sawtooth, freq=16 -> 1,2,...,255,0 consecutive samples. sync_out with the 0 sample.
//  Offset 2048 on the square test -> sequence 0,255,255,0. Mode switch to saw mid-run changes only samples enabled after the switch.
//  en toggled 1,0,0,1 -> out_valid pattern 1,0,0,1 delayed 3 clk; acc advances twice; waveform holds in gaps.
//  Sine, freq=64, 256-sample run -> symmetric about 128, min>=1, max=255, matches model bit-exact.
//   phase_clr, then rst mid-stream -> no valid for 3 clk after rst.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants for the DDS waveform generator: mode encodings and pipeline latency.
package dds_pkg;

  localparam logic [1:0] MODE_SINE = 2'd0;
  localparam logic [1:0] MODE_TRI  = 2'd1;
  localparam logic [1:0] MODE_SAW  = 2'd2;
  localparam logic [1:0] MODE_SQR  = 2'd3;

  // Clock edges from the accumulator step to the registered waveform.
  localparam int unsigned PIPE_LAT = 3;

endpackage

// File: rtl/dds_quarter_rom.sv
// Quarter-wave sine ROM with registered output; contents are built at elaboration time.
module dds_quarter_rom #(
  parameter int unsigned LUT_AW = 10,
  parameter int unsigned OUT_W  = 12
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr,
  output logic [OUT_W-2:0]  data
);

  localparam int unsigned DEPTH = 1 << LUT_AW;

  // Half-step sample points keep the quarter symmetric, so folding by ~addr is exact.
  function automatic logic [OUT_W-2:0] rom_entry(int unsigned idx);
    real amp;
    real ph;
    amp = real'((1 << (OUT_W - 1)) - 1);
    ph  = (real'(idx) + 0.5) * 3.14159265358979323846 / real'(1 << (LUT_AW + 1));
    return (OUT_W - 1)'($rtoi(amp * $sin(ph) + 0.5));
  endfunction

  logic [OUT_W-2:0] rom_tbl [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom_tbl[i] = rom_entry(i);
  end

  always_ff @(posedge clk) begin
    data <= rom_tbl[addr];
  end

endmodule

// File: rtl/dds_gen.sv
// Multi-waveform DDS: phase accumulator, per-sample offset, quarter-wave sine,
// triangle, sawtooth and square outputs with valid and wrap-sync flags.
module dds_gen
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned LUT_AW  = 10,
  parameter int unsigned OUT_W   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] freq_ctrl,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic [1:0]         mode,
  output logic [OUT_W-1:0]   waveform,
  output logic               out_valid,
  output logic               sync_out
);

  localparam int unsigned KEEP_W = (OUT_W + 1 > LUT_AW + 2) ? OUT_W + 1 : LUT_AW + 2;
  localparam int unsigned LO_W   = PHASE_W - KEEP_W;
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W - 1){1'b0}}};

  // S1: accumulator step, capturing offset and mode with the sample
  logic [PHASE_W-1:0] acc_q, off_q;
  logic [PHASE_W:0]   acc_sum;
  logic               v1_q, w1_q;
  logic [1:0]         mode1_q;

  assign acc_sum = {1'b0, acc_q} + {1'b0, freq_ctrl};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      off_q   <= '0;
      v1_q    <= 1'b0;
      w1_q    <= 1'b0;
      mode1_q <= MODE_SINE;
    end else begin
      v1_q <= en;
      if (phase_clr) begin
        acc_q <= '0;
      end else if (en) begin
        acc_q <= acc_sum[PHASE_W-1:0];
      end
      if (en) begin
        w1_q    <= acc_sum[PHASE_W] & ~phase_clr;
        off_q   <= phase_offset;
        mode1_q <= mode;
      end
    end
  end

  // S2: only the top KEEP_W phase bits are consumed; the low part contributes its carry.
  logic              lo_carry;
  logic [KEEP_W-1:0] phase_top;

  if (LO_W > 0) begin : g_lo
    assign lo_carry = acc_q[LO_W-1:0] > ~off_q[LO_W-1:0];
  end else begin : g_no_lo
    assign lo_carry = 1'b0;
  end

  assign phase_top = acc_q[PHASE_W-1 -: KEEP_W] + off_q[PHASE_W-1 -: KEEP_W] + KEEP_W'(lo_carry);

  logic [KEEP_W-1:0] p2_q;
  logic              v2_q, w2_q;
  logic [1:0]        mode2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p2_q    <= '0;
      v2_q    <= 1'b0;
      w2_q    <= 1'b0;
      mode2_q <= MODE_SINE;
    end else begin
      p2_q    <= phase_top;
      v2_q    <= v1_q;
      w2_q    <= w1_q;
      mode2_q <= mode1_q;
    end
  end

  // Odd quadrants walk the quarter table backwards.
  logic [LUT_AW-1:0] quad_idx, rom_addr;
  logic [OUT_W-2:0]  rom_data;

  assign quad_idx = p2_q[KEEP_W-3 -: LUT_AW];
  assign rom_addr = p2_q[KEEP_W-2] ? ~quad_idx : quad_idx;

  dds_quarter_rom #(
    .LUT_AW(LUT_AW),
    .OUT_W (OUT_W)
  ) u_rom (
    .clk (clk),
    .addr(rom_addr),
    .data(rom_data)
  );

  // S3: phase bits travel alongside the ROM read
  logic [OUT_W:0] p3_q;
  logic           v3_q, w3_q;
  logic [1:0]     mode3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p3_q    <= '0;
      v3_q    <= 1'b0;
      w3_q    <= 1'b0;
      mode3_q <= MODE_SINE;
    end else begin
      p3_q    <= p2_q[KEEP_W-1 -: OUT_W + 1];
      v3_q    <= v2_q;
      w3_q    <= w2_q;
      mode3_q <= mode2_q;
    end
  end

  // S4: waveform select, registered and held between samples
  logic [OUT_W-1:0] tri_t, wave_d;

  always_comb begin
    tri_t  = p3_q[OUT_W-1:0];
    wave_d = '0;
    unique case (mode3_q)
      MODE_SINE: wave_d = p3_q[OUT_W] ? MID - {1'b0, rom_data} : MID + {1'b0, rom_data};
      MODE_TRI:  wave_d = p3_q[OUT_W] ? ~tri_t : tri_t;
      MODE_SAW:  wave_d = p3_q[OUT_W:1];
      MODE_SQR:  wave_d = p3_q[OUT_W] ? '0 : '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waveform  <= MID;
      out_valid <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      out_valid <= v3_q;
      sync_out  <= v3_q & w3_q;
      if (v3_q) begin
        waveform <= wave_d;
      end
    end
  end

endmodule

// File: tb/tb_dds_gen.sv
// Self-checking bench for dds_gen: directed scenarios plus a randomized run against
// a per-cycle schedule of expected samples computed from phase arithmetic.
module tb_dds_gen;
  import dds_pkg::*;

  localparam int unsigned PW = 12;
  localparam int unsigned AW = 4;
  localparam int unsigned OW = 8;
  localparam int unsigned NMAX = 2048;
  localparam real PI = 3.14159265358979323846;

  logic          clk;
  logic          rst, en, phase_clr;
  logic [PW-1:0] freq_ctrl, phase_offset;
  logic [1:0]    mode;
  logic [OW-1:0] waveform;
  logic          out_valid, sync_out;

  dds_gen #(
    .PHASE_W(PW),
    .LUT_AW (AW),
    .OUT_W  (OW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .phase_clr   (phase_clr),
    .freq_ctrl   (freq_ctrl),
    .phase_offset(phase_offset),
    .mode        (mode),
    .waveform    (waveform),
    .out_valid   (out_valid),
    .sync_out    (sync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output after clock edge n, filled in when the sample is requested.
  bit          ev [NMAX];
  bit          es [NMAX];
  bit          ec [NMAX];
  logic [7:0]  ew [NMAX];
  int unsigned n = 0;
  int unsigned acc_m = 0;
  logic [7:0]  last_w = 8'd128;
  bit          collect = 1'b0;
  int unsigned sine_q[$];
  int unsigned cmp_cnt = 0;
  int unsigned err_cnt = 0;

  function automatic logic [7:0] ref_wave(logic [1:0] m, int unsigned p);
    int unsigned q, i, r, t;
    case (m)
      MODE_SINE: begin
        q = p / 1024;
        i = (p % 1024) / 64;
        if (q % 2 == 1) i = 15 - i;
        r = $rtoi(127.0 * $sin((real'(i) + 0.5) * PI / 32.0) + 0.5);
        return (q >= 2) ? 8'(128 - r) : 8'(128 + r);
      end
      MODE_TRI: begin
        t = (p / 8) % 256;
        return (p >= 2048) ? 8'(255 - t) : 8'(t);
      end
      MODE_SAW: return 8'(p / 16);
      default:  return (p >= 2048) ? 8'd0 : 8'd255;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    cmp_cnt++;
    assert (got === exp)
    else begin
      err_cnt++;
      $error("FAIL %s @%0d: observed %0h expected %0h", tag, n, got, exp);
    end
  endtask

  task automatic tick();
    int unsigned s;
    bit          wrap;
    if (rst) begin
      acc_m = 0;
      for (int k = 0; k <= int'(PIPE_LAT); k++) ev[n + k] = 1'b0;
    end else begin
      wrap = 1'b0;
      if (phase_clr) begin
        acc_m = 0;
      end else if (en) begin
        s     = acc_m + freq_ctrl;
        wrap  = s >= 4096;
        acc_m = s % 4096;
      end
      if (en) begin
        ev[n + PIPE_LAT] = 1'b1;
        es[n + PIPE_LAT] = wrap;
        ec[n + PIPE_LAT] = collect && (mode == MODE_SINE);
        ew[n + PIPE_LAT] = ref_wave(mode, (acc_m + phase_offset) % 4096);
      end
    end
    @(posedge clk);
    #1;
    if (rst) last_w = 8'd128;
    else if (ev[n]) last_w = ew[n];
    check("out_valid", out_valid, ev[n]);
    check("waveform", waveform, last_w);
    check("sync_out", sync_out, ev[n] & es[n]);
    if (ev[n] && ec[n]) sine_q.push_back(waveform);
    n++;
  endtask

  initial begin
    int unsigned smin, smax;
    rst = 1'b1; en = 1'b0; phase_clr = 1'b0;
    freq_ctrl = '0; phase_offset = '0; mode = MODE_SQR;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // Square at quarter rate, then half-cycle offset, then switch to saw mid-run
    freq_ctrl = 12'd1024; en = 1'b1;
    repeat (12) tick();
    phase_offset = 12'd2048;
    repeat (8) tick();
    mode = MODE_SAW;
    repeat (4) tick();

    // Full sawtooth ramp starting from a cleared phase
    phase_offset = '0; freq_ctrl = 12'd16; phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    repeat (258) tick();

    // Sample requests with gaps
    mode = MODE_TRI; freq_ctrl = 12'($urandom_range(1, 4095));
    en = 1'b1; tick(); en = 1'b0; tick(); tick(); en = 1'b1; tick();
    en = 1'b0; repeat (4) tick();

    // Zero frequency: constant phase, never syncs
    freq_ctrl = '0; en = 1'b1; mode = MODE_SAW;
    repeat (6) tick();

    // Sine run for symmetry and range checks
    mode = MODE_SINE; freq_ctrl = 12'd64; phase_clr = 1'b1; collect = 1'b1;
    tick();
    phase_clr = 1'b0;
    repeat (260) tick();
    collect = 1'b0; en = 1'b0;
    repeat (4) tick();

    check("sine_count", sine_q.size() >= 256, 1);
    if (sine_q.size() >= 256) begin
      smin = 255; smax = 0;
      for (int k = 0; k < 256; k++) begin
        if (sine_q[k] < smin) smin = sine_q[k];
        if (sine_q[k] > smax) smax = sine_q[k];
      end
      check("sine_max", smax, 255);
      check("sine_min_ge1", smin >= 1, 1);
      for (int k = 0; k < 32; k++) check("sine_sym", sine_q[k] + sine_q[k + 32], 256);
    end

    // Clear without a sample, then reset in the middle of a stream
    mode = MODE_TRI; freq_ctrl = 12'($urandom_range(1, 4095)); phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0; en = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();

    // Randomized traffic
    repeat (300) begin
      en        = $urandom_range(0, 9) < 7;
      phase_clr = $urandom_range(0, 19) == 0;
      rst       = $urandom_range(0, 99) == 0;
      if ($urandom_range(0, 15) == 0) begin
        mode         = 2'($urandom);
        phase_offset = 12'($urandom);
        case ($urandom_range(0, 3))
          0:       freq_ctrl = 12'd0;
          1:       freq_ctrl = 12'd2048;
          default: freq_ctrl = 12'($urandom);
        endcase
      end
      tick();
    end
    rst = 1'b0; en = 1'b0; phase_clr = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
